// File: rtl/serpent_pkg.sv
// Shared Serpent constants, sbox tables and word helpers used by the key schedule
// and the round datapath.
package serpent_pkg;

    localparam int          SUBKEYS = 33;
    localparam logic [31:0] PHI     = 32'h9e3779b9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GEN  = 2'd1,
        ST_DONE = 2'd2
    } ks_state_e;

    // Row n is sbox S[n]; column is the 4-bit input value.
    localparam logic [3:0] SBOX [8][16] = '{
        '{4'd3,  4'd8,  4'd15, 4'd1,  4'd10, 4'd6,  4'd5,  4'd11, 4'd14, 4'd13, 4'd4,  4'd2,  4'd7,  4'd0,  4'd9,  4'd12},
        '{4'd15, 4'd12, 4'd2,  4'd7,  4'd9,  4'd0,  4'd5,  4'd10, 4'd1,  4'd11, 4'd14, 4'd8,  4'd6,  4'd13, 4'd3,  4'd4},
        '{4'd8,  4'd6,  4'd7,  4'd9,  4'd3,  4'd12, 4'd10, 4'd15, 4'd13, 4'd1,  4'd14, 4'd4,  4'd0,  4'd11, 4'd5,  4'd2},
        '{4'd0,  4'd15, 4'd11, 4'd8,  4'd12, 4'd9,  4'd6,  4'd3,  4'd13, 4'd1,  4'd2,  4'd4,  4'd10, 4'd7,  4'd5,  4'd14},
        '{4'd1,  4'd15, 4'd8,  4'd3,  4'd12, 4'd0,  4'd11, 4'd6,  4'd2,  4'd5,  4'd4,  4'd10, 4'd9,  4'd14, 4'd7,  4'd13},
        '{4'd15, 4'd5,  4'd2,  4'd11, 4'd4,  4'd10, 4'd9,  4'd12, 4'd0,  4'd3,  4'd14, 4'd8,  4'd13, 4'd6,  4'd7,  4'd1},
        '{4'd7,  4'd2,  4'd12, 4'd5,  4'd8,  4'd4,  4'd6,  4'd11, 4'd14, 4'd9,  4'd1,  4'd15, 4'd13, 4'd3,  4'd10, 4'd0},
        '{4'd1,  4'd13, 4'd15, 4'd0,  4'd14, 4'd8,  4'd2,  4'd11, 4'd7,  4'd4,  4'd12, 4'd10, 4'd9,  4'd3,  4'd5,  4'd6}
    };

    function automatic logic [31:0] rotl11(input logic [31:0] x);
        return {x[20:0], x[31:21]};
    endfunction

    // One step of the prekey recurrence: rotl11(w(i-8)^w(i-5)^w(i-3)^w(i-1)^PHI^i).
    function automatic logic [31:0] prekey_word(
        input logic [31:0] w_m8,
        input logic [31:0] w_m5,
        input logic [31:0] w_m3,
        input logic [31:0] w_m1,
        input logic [31:0] idx
    );
        return rotl11(w_m8 ^ w_m5 ^ w_m3 ^ w_m1 ^ PHI ^ idx);
    endfunction

endpackage

// File: rtl/serpent_ks_sbox.sv
// Bitsliced application of one Serpent sbox across four 32-bit words; word n
// occupies bits [32n+31:32n] on both input and output.
module serpent_ks_sbox
    import serpent_pkg::*;
(
    input  logic [127:0] i_words,
    input  logic [2:0]   i_sbox_idx,
    output logic [127:0] o_words
);

    logic [3:0] nib;
    logic [3:0] sub;

    // Column j gathers bit j of every word into a nibble, word 3 as its MSB.
    always_comb begin
        o_words = '0;
        nib     = '0;
        sub     = '0;
        for (int j = 0; j < 32; j++) begin
            nib = {i_words[96 + j], i_words[64 + j], i_words[32 + j], i_words[j]};
            sub = SBOX[i_sbox_idx][nib];
            o_words[j]      = sub[0];
            o_words[32 + j] = sub[1];
            o_words[64 + j] = sub[2];
            o_words[96 + j] = sub[3];
        end
    end

endmodule

// File: rtl/serpent_key_schedule.sv
// Expands a 128/192/256-bit user key into the 33 bitsliced Serpent subkeys,
// one subkey per cycle, and serves them to the decryption core by index.
module serpent_key_schedule
    import serpent_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rstn,
    input  logic         i_key_load,
    input  logic [255:0] i_key,
    input  logic [1:0]   i_key_len,
    input  logic [5:0]   i_address,
    output logic [127:0] o_subkey,
    output logic         o_subkey_valid,
    output logic         o_busy
);

    ks_state_e    state_q, state_d;
    logic [5:0]   k_q, k_d;
    logic         valid_q, valid_d;
    logic         busy_q, busy_d;
    logic [255:0] win_q, win_d;

    logic [127:0] rf_q [SUBKEYS];
    logic         rf_we;

    logic [255:0] padded_key;
    logic [31:0]  w_new0, w_new1, w_new2, w_new3;
    logic [127:0] sbox_out;
    logic [2:0]   sbox_idx;

    // Short keys get a single 1 directly above their MSB, zeros beyond.
    always_comb begin
        padded_key = i_key;
        case (i_key_len)
            2'b00:   padded_key = {127'd0, 1'b1, i_key[127:0]};
            2'b01:   padded_key = {63'd0, 1'b1, i_key[191:0]};
            default: padded_key = i_key;
        endcase
    end

    // Window word n holds w(4k+n-8); the four new words chain through each other.
    always_comb begin
        w_new0 = prekey_word(win_q[31:0],   win_q[127:96],  win_q[191:160], win_q[255:224],
                             {24'd0, k_q, 2'd0});
        w_new1 = prekey_word(win_q[63:32],  win_q[159:128], win_q[223:192], w_new0,
                             {24'd0, k_q, 2'd1});
        w_new2 = prekey_word(win_q[95:64],  win_q[191:160], win_q[255:224], w_new1,
                             {24'd0, k_q, 2'd2});
        w_new3 = prekey_word(win_q[127:96], win_q[223:192], w_new0,         w_new2,
                             {24'd0, k_q, 2'd3});
    end

    assign sbox_idx = 3'd3 - k_q[2:0];

    serpent_ks_sbox u_sbox (
        .i_words    ({w_new3, w_new2, w_new1, w_new0}),
        .i_sbox_idx (sbox_idx),
        .o_words    (sbox_out)
    );

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        win_d   = win_q;
        rf_we   = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (i_key_load) begin
                    win_d   = padded_key;
                    k_d     = '0;
                    valid_d = 1'b0;
                    busy_d  = 1'b1;
                    state_d = ST_GEN;
                end
            end
            ST_GEN: begin
                rf_we = 1'b1;
                win_d = {w_new3, w_new2, w_new1, w_new0, win_q[255:128]};
                k_d   = k_q + 6'd1;
                if (k_q == 6'(SUBKEYS - 1)) begin
                    k_d     = '0;
                    valid_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            win_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            win_q   <= win_d;
        end
    end

    // Subkey storage is deliberately not reset; the read gate hides stale contents.
    always_ff @(posedge i_clk) begin
        if (rf_we) begin
            rf_q[k_q] <= sbox_out;
        end
    end

    always_comb begin
        o_subkey = '0;
        if (valid_q && (i_address <= 6'(SUBKEYS - 1))) begin
            o_subkey = rf_q[i_address];
        end
    end

    assign o_subkey_valid = valid_q;
    assign o_busy         = busy_q;

endmodule

// File: tb/tb_serpent_key_schedule.sv
// Randomized self-checking bench for serpent_key_schedule against a word-array
// model of the Serpent key expansion.
module tb_serpent_key_schedule;

    logic         i_clk = 1'b0;
    logic         i_rstn = 1'b0;
    logic         i_key_load = 1'b0;
    logic [255:0] i_key = '0;
    logic [1:0]   i_key_len = '0;
    logic [5:0]   i_address = '0;
    logic [127:0] o_subkey;
    logic         o_subkey_valid;
    logic         o_busy;

    int vectors = 0;
    int miscompares = 0;
    int cycles;

    logic [127:0] expSubkey [33];

    int sbTable [8][16] = '{
        '{3, 8, 15, 1, 10, 6, 5, 11, 14, 13, 4, 2, 7, 0, 9, 12},
        '{15, 12, 2, 7, 9, 0, 5, 10, 1, 11, 14, 8, 6, 13, 3, 4},
        '{8, 6, 7, 9, 3, 12, 10, 15, 13, 1, 14, 4, 0, 11, 5, 2},
        '{0, 15, 11, 8, 12, 9, 6, 3, 13, 1, 2, 4, 10, 7, 5, 14},
        '{1, 15, 8, 3, 12, 0, 11, 6, 2, 5, 4, 10, 9, 14, 7, 13},
        '{15, 5, 2, 11, 4, 10, 9, 12, 0, 3, 14, 8, 13, 6, 7, 1},
        '{7, 2, 12, 5, 8, 4, 6, 11, 14, 9, 1, 15, 13, 3, 10, 0},
        '{1, 13, 15, 0, 14, 8, 2, 11, 7, 4, 12, 10, 9, 3, 5, 6}
    };

    serpent_key_schedule dut (
        .i_clk          (i_clk),
        .i_rstn         (i_rstn),
        .i_key_load     (i_key_load),
        .i_key          (i_key),
        .i_key_len      (i_key_len),
        .i_address      (i_address),
        .o_subkey       (o_subkey),
        .o_subkey_valid (o_subkey_valid),
        .o_busy         (o_busy)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Whole-schedule model: expand all 132 prekey words first, then sbox each group of four.
    function automatic void buildModel(input logic [255:0] key, input logic [1:0] len);
        logic [31:0]  w [140];
        logic [255:0] p;
        logic [31:0]  t;
        logic [127:0] sk;
        int           box;
        int           nib;
        int           outv;
        p = key;
        if (len == 2'b00) begin
            p[255:128] = '0;
            p[128] = 1'b1;
        end else if (len == 2'b01) begin
            p[255:192] = '0;
            p[192] = 1'b1;
        end
        for (int i = 0; i < 8; i++) w[i] = p[32*i +: 32];
        for (int i = 0; i < 132; i++) begin
            t = w[i] ^ w[i+3] ^ w[i+5] ^ w[i+7] ^ 32'h9e3779b9 ^ 32'(i);
            w[i+8] = (t << 11) | (t >> 21);
        end
        for (int k = 0; k < 33; k++) begin
            box = (35 - k) % 8;
            sk = '0;
            for (int j = 0; j < 32; j++) begin
                nib = 0;
                for (int b = 0; b < 4; b++) nib = nib | (int'(w[8 + 4*k + b][j]) << b);
                outv = sbTable[box][nib];
                for (int b = 0; b < 4; b++) sk[32*b + j] = outv[b];
            end
            expSubkey[k] = sk;
        end
    endfunction

    function automatic logic [255:0] randomKey();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic applyStimulus(input logic [255:0] key, input logic [1:0] len);
        buildModel(key, len);
        @(negedge i_clk);
        i_key = key;
        i_key_len = len;
        i_key_load = 1'b1;
        @(negedge i_clk);
        i_key_load = 1'b0;
    endtask

    // Counts edges after the load edge until valid; reads during generation must be zero.
    task automatic waitValid(input int loadAt, output int cnt);
        cnt = 0;
        while (!o_subkey_valid && cnt < 60) begin
            i_address = 6'($urandom_range(0, 63));
            #1;
            checkOutput("gen_read_zero", o_subkey, '0);
            checkOutput("gen_busy", 128'(o_busy), 128'd1);
            if (cnt == loadAt) begin
                i_key = randomKey();
                i_key_len = 2'($urandom_range(0, 3));
                i_key_load = 1'b1;
            end
            @(negedge i_clk);
            i_key_load = 1'b0;
            cnt++;
        end
        checkOutput("latency", 128'(cnt), 128'd33);
        checkOutput("done_busy", 128'(o_busy), 128'd0);
    endtask

    task automatic readAll(input string tag);
        for (int a = 0; a < 33; a++) begin
            i_address = 6'(a);
            #1;
            checkOutput(tag, o_subkey, expSubkey[a]);
        end
        i_address = 6'd33;
        #1;
        checkOutput("addr33_zero", o_subkey, '0);
        i_address = 6'd63;
        #1;
        checkOutput("addr63_zero", o_subkey, '0);
    endtask

    initial begin
        logic [255:0] key;
        $display("[TB] start");
        #12;
        checkOutput("rst_valid", 128'(o_subkey_valid), 128'd0);
        checkOutput("rst_busy", 128'(o_busy), 128'd0);
        checkOutput("rst_subkey", o_subkey, '0);
        @(negedge i_clk);
        i_rstn = 1'b1;

        applyStimulus('0, 2'b00);
        waitValid(-1, cycles);
        readAll("zero128");

        for (int b = 0; b < 32; b++) key[8*b +: 8] = 8'(b);
        applyStimulus(key, 2'b10);
        waitValid(-1, cycles);
        readAll("bytes256");

        applyStimulus(randomKey(), 2'b01);
        waitValid(-1, cycles);
        readAll("rand192");

        applyStimulus(randomKey(), 2'($urandom_range(0, 3)));
        waitValid(10, cycles);
        readAll("gen_load_ignored");

        applyStimulus(randomKey(), 2'b10);
        checkOutput("done_load_valid", 128'(o_subkey_valid), 128'd0);
        checkOutput("done_load_busy", 128'(o_busy), 128'd1);
        waitValid(-1, cycles);
        readAll("reload");

        applyStimulus(randomKey(), 2'b00);
        repeat (20) @(negedge i_clk);
        #2;
        i_rstn = 1'b0;
        #1;
        checkOutput("midgen_rst_valid", 128'(o_subkey_valid), 128'd0);
        checkOutput("midgen_rst_busy", 128'(o_busy), 128'd0);
        @(negedge i_clk);
        i_rstn = 1'b1;
        repeat (3) @(negedge i_clk);
        checkOutput("post_rst_idle_busy", 128'(o_busy), 128'd0);
        checkOutput("post_rst_idle_valid", 128'(o_subkey_valid), 128'd0);
        applyStimulus(randomKey(), 2'b01);
        waitValid(-1, cycles);
        readAll("after_reset");

        for (int n = 0; n < 4; n++) begin
            applyStimulus(randomKey(), 2'($urandom_range(0, 3)));
            waitValid(-1, cycles);
            readAll("random_key");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serpent_key_schedule.md
Name: serpent_key_schedule

Overview:
Upstream stage of serpent_de. It expands a 128/192/256-bit user key into the 33 Serpent round subkeys and stores them in a 33x128 register file. It then serves them combinationally to the decryption core, which uses its round counter as the lookup address. The block asserts o_subkey_valid once the full set of subkeys is ready. This output drives serpent_de i_subkey_valid; o_subkey drives i_key; i_address is driven by o_address.

Parameters:
SUBKEYS, 33, number of 128-bit round subkeys generated and stored
PHI, 32'h9e3779b9, golden-ratio constant in the prekey recurrence

Ports:
i_clk  input  1  clock
i_rstn  input  1  asynchronous active-low reset
i_key_load  input  1  single-cycle pulse; start expansion of i_key
i_key  input  256  user key; bits [31:0] are word w(-8)
i_key_len  input  2  00=128, 01=192, 10=256, 11 treated as 256
i_address  input  6  subkey index, 0..32
o_subkey  output  128  subkey[i_address], combinational read
o_subkey_valid  output  1  all 33 subkeys written and stable
o_busy  output  1  expansion in progress

Behaviour:
- Reset is asynchronous and active-low.
  - State returns to IDLE; o_subkey_valid=0; o_busy=0; generation counter k=0.
  - Register-file contents are not reset.
  - o_subkey reads 0 whenever o_subkey_valid=0, so no stale or partial key is ever visible.
- FSM states: IDLE, GEN, DONE.
  - IDLE: i_key_load=1 at edge E0 does the following:
    - Latch the padded key into an 8x32 prekey window.
    - Set k=0 and o_busy=1, and move to GEN.
  - GEN: each cycle computes four prekey words combinationally, chained in sequence.
    - Recurrence: w(i) = rotl11(w(i-8) ^ w(i-5) ^ w(i-3) ^ w(i-1) ^ PHI ^ i), with i = 4k..4k+3 as a 32-bit index.
    - The sbox S[(3-k) mod 8] is applied bitsliced. For column j=0..31 the input nibble is {w(4k+3)[j], w(4k+2)[j], w(4k+1)[j], w(4k)[j]}, and the output bits return to the same positions.
    - The result is written to subkey[k] at edge E(k+1). The window then shifts by 4 words and k increments.
    - Subkeys stay in bitslice form; no IP is applied, to match the round datapath.
  - GEN leaves at the edge that writes subkey[32], which is E33. At that edge o_subkey_valid<=1, o_busy<=0, and state<=DONE.
  - Load-to-valid latency is exactly 33 cycles.
  - DONE: holds. i_key_load=1 clears o_subkey_valid at the next edge, sets o_busy=1 and starts GEN again with the new key.
- Padding for short keys: append a single 1 bit directly above the key MSB and zero-fill the rest.
  - 128-bit key: bit 128 set.
  - 192-bit key: bit 192 set.
  - 256-bit key: no padding.
- i_key_load while in GEN is ignored; the current expansion completes unchanged.
- i_key and i_key_len are sampled only at the load edge; later changes have no effect.
- Read port:
  - o_subkey = subkey[i_address] when o_subkey_valid=1 and i_address<=32.
  - i_address>=33 returns 128'h0; serpent_de can index 33 transiently.
- Reset asserted mid-GEN aborts the expansion. A new i_key_load is required after reset release.

Decomposition:
- serpent_pkg holds:
  - PHI, SUBKEYS and state encodings.
  - The eight 4-bit Serpent sbox tables, shared with the round modules.
  - A rotl11 function.
- One sub-module, serpent_ks_sbox: inputs 4x32 words and a 3-bit sbox index; outputs 4x32 bitsliced sbox result. It is purely combinational and reusable for verification.

Test Plan:
- 128-bit all-zero key, load pulse -> first prekey word w0=32'hBBCDCCF1 (probe); o_subkey_valid rises exactly 33 cycles after load; all 33 subkeys match the team C reference model.
- 256-bit key 0x00..1F byte pattern, i_key_len=10 -> subkeys 0..32 match the model; i_address=33 and 63 -> o_subkey=0.
- 192-bit key, read all subkeys before valid -> o_subkey=0 throughout GEN; correct values after valid.
- Second i_key_load during GEN at cycle 10 -> ignored, valid still at cycle 33 with the first key's subkeys. A load in DONE -> valid drops next cycle and the new key's subkeys appear 33 cycles later.
- Reset pulse at GEN cycle 20 -> valid=0, busy=0 immediately; a fresh load produces a correct full schedule.
- Integration with serpent_de: ciphertext of a known Serpent KAT vector decrypts to the expected plaintext.
